decode_pipe_reg: RTL

//  Parametrised elastic decode->execute pipeline register for the simple CPU.

---
 rtl/decode_pipe_reg_if.sv | 35 +++
 rtl/decode_pipe_reg.sv | 126 ++++++++++++
 2 files changed

// File: rtl/decode_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// decode_pipe_reg_if
//   Handshake/data bundle between the decoder, the decode->execute pipeline
//   register and the execute stage.
//   slave  : pipeline register side (receives upstream, drives downstream)
//   master : environment side (decoder + execute stage)
//   Upstream   : FLUSH_IN, VALID_IN, CTRL_IN, PC_IN   -> register, READY_OUT <-
//   Downstream : VALID_OUT, CTRL_OUT, PC_OUT, STALL_CNT_OUT <- register, READY_IN ->
// -----------------------------------------------------------------------------
interface decode_pipe_reg_if #(
   parameter int CTRL_W = 14,
   parameter int PC_W   = 8,
   parameter int CNT_W  = 8
);
   logic              FLUSH_IN;
   logic              VALID_IN;
   logic              READY_OUT;
   logic [CTRL_W-1:0] CTRL_IN;
   logic [PC_W-1:0]   PC_IN;
   logic              VALID_OUT;
   logic              READY_IN;
   logic [CTRL_W-1:0] CTRL_OUT;
   logic [PC_W-1:0]   PC_OUT;
   logic [CNT_W-1:0]  STALL_CNT_OUT;

   modport slave (
      input  FLUSH_IN, VALID_IN, CTRL_IN, PC_IN, READY_IN,
      output READY_OUT, VALID_OUT, CTRL_OUT, PC_OUT, STALL_CNT_OUT
   );

   modport master (
      output FLUSH_IN, VALID_IN, CTRL_IN, PC_IN, READY_IN,
      input  READY_OUT, VALID_OUT, CTRL_OUT, PC_OUT, STALL_CNT_OUT
   );
endinterface

// File: rtl/decode_pipe_reg.sv
// -----------------------------------------------------------------------------
// decode_pipe_reg
//   Elastic decode->execute pipeline register with a 2-entry skid buffer.
//   Carries the packed control bundle
//   (AR, BR, ALU[3:0], input, wren, writeAd[2:0], ADR_MUX, write, PC_load)
//   and the instruction PC.
//   Ports:
//     CLK    - clock, all state on posedge
//     RST_N  - synchronous active-low reset
//     bus    - decode_pipe_reg_if.slave (valid/ready in and out, flush,
//              control/PC data, saturating stall counter)
//   Main entry M drives the outputs; skid entry S only fills when the stage
//   accepts a bundle while downstream is stalling. READY_OUT and VALID_OUT are
//   flops, so there is no combinational READY_IN -> READY_OUT path.
// -----------------------------------------------------------------------------
module decode_pipe_reg #(
   parameter int                CTRL_W    = 14,
   parameter int                PC_W      = 8,
   parameter int                CNT_W     = 8,
   parameter logic [CTRL_W-1:0] NOP_VALUE = '0
) (
   input  logic              CLK,
   input  logic              RST_N,
   decode_pipe_reg_if.slave  bus
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
   logic [PC_W-1:0]   m_pc_q, m_pc_d;
   logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
   logic [PC_W-1:0]   s_pc_q, s_pc_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tin, tout;

   assign tin  = bus.VALID_IN & ready_q;
   assign tout = valid_q & bus.READY_IN;

   always_comb begin
      state_d  = state_q;
      m_ctrl_d = m_ctrl_q;
      m_pc_d   = m_pc_q;
      s_ctrl_d = s_ctrl_q;
      s_pc_d   = s_pc_q;
      cnt_d    = cnt_q;

      unique case (state_q)
         EMPTY: begin
            if (tin) begin
               state_d  = ONE;
               m_ctrl_d = bus.CTRL_IN;
               m_pc_d   = bus.PC_IN;
            end
         end
         ONE: begin
            if (tin && tout) begin
               m_ctrl_d = bus.CTRL_IN;
               m_pc_d   = bus.PC_IN;
            end else if (tin) begin
               state_d  = FULL;
               s_ctrl_d = bus.CTRL_IN;
               s_pc_d   = bus.PC_IN;
            end else if (tout) begin
               state_d  = EMPTY;
            end
         end
         FULL: begin
            if (tout) begin
               state_d  = ONE;
               m_ctrl_d = s_ctrl_q;
               m_pc_d   = s_pc_q;
            end
         end
         default: state_d = EMPTY;
      endcase

      // Flush drops everything held and any same-cycle tin; PC_OUT keeps its
      // last value so only the control word is forced to the NOP.
      if (bus.FLUSH_IN) begin
         state_d = EMPTY;
         m_pc_d  = m_pc_q;
      end

      // The NOP substitution is folded into M's next value so CTRL_OUT is a
      // plain flop output with no gating after the register.
      if (state_d == EMPTY) m_ctrl_d = NOP_VALUE;

      valid_d = (state_d != EMPTY);
      ready_d = (state_d != FULL);

      if (valid_q && !bus.READY_IN && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= EMPTY;
         m_ctrl_q <= NOP_VALUE;
         m_pc_q   <= '0;
         s_ctrl_q <= '0;
         s_pc_q   <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         m_ctrl_q <= m_ctrl_d;
         m_pc_q   <= m_pc_d;
         s_ctrl_q <= s_ctrl_d;
         s_pc_q   <= s_pc_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.VALID_OUT     = valid_q;
   assign bus.READY_OUT     = ready_q;
   assign bus.CTRL_OUT      = m_ctrl_q;
   assign bus.PC_OUT        = m_pc_q;
   assign bus.STALL_CNT_OUT = cnt_q;

endmodule
